// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// timer_pkg : shared constants for the timer sequencer
// Rev 1.0   : initial release
// ============================================================================
package timer_pkg;

    localparam int c_WIDTH = 32;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HALT = 2'd2;

    localparam logic c_MOD_PERIODIC = 1'b0;
    localparam logic c_MOD_ONESHOT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// timer_prescaler : divides the clock by PRE+1 while running
// Rev 1.0         : initial release
// ============================================================================
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_run,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_pre,
    output logic             o_wrap,
    output logic             o_tick
);

    logic [WIDTH-1:0] r_psc;
    logic             r_tick;

    // >= rather than == so a PRE lowered below the running count still wraps
    assign o_wrap = i_run && !i_clr && (r_psc >= i_pre);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_psc  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= o_wrap;
            if (i_clr) begin
                r_psc <= '0;
            end else if (i_run) begin
                r_psc <= o_wrap ? '0 : r_psc + 1'b1;
            end
        end
    end

    assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
// timer_ctrl : timer state machine, main counter and event bookkeeping
// Rev 1.0    : initial release
// ============================================================================
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] TIM_PRE_i,
    input  logic [WIDTH-1:0] TIM_ARE_i,
    input  logic             TIM_CLR_i,
    input  logic             TIM_ENA_i,
    input  logic             TIM_MOD_i,
    input  logic             TIM_EVC_i,
    output logic             TIM_CLR_o,
    output logic [WIDTH-1:0] TIM_CNT_o,
    output logic [WIDTH-1:0] TIM_EVN_o,
    output logic             TIM_EVC_o,
    output logic             tick_o,
    output logic             irq_o
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_evn;
    logic             r_evc;
    logic             r_irq;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_evn_nxt;
    logic             w_evc_nxt;
    logic             w_irq_nxt;
    logic             w_run;
    logic             w_wrap;
    logic             w_event;

    // The edge that sees ENA low already leaves RUN, so it must not count
    assign w_run   = (r_state == c_RUN) && TIM_ENA_i;
    assign w_event = w_wrap && (r_cnt >= TIM_ARE_i);

    timer_prescaler #(
        .WIDTH (WIDTH)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_run  (w_run),
        .i_clr  (TIM_CLR_i),
        .i_pre  (TIM_PRE_i),
        .o_wrap (w_wrap),
        .o_tick (tick_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (TIM_CLR_i) begin
            w_state_nxt = TIM_ENA_i ? c_RUN : c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  w_state_nxt = TIM_ENA_i ? c_RUN : c_IDLE;
                c_RUN: begin
                    if (!TIM_ENA_i) begin
                        w_state_nxt = c_IDLE;
                    end else if (w_event && (TIM_MOD_i == c_MOD_ONESHOT)) begin
                        w_state_nxt = c_HALT;
                    end
                end
                c_HALT:  w_state_nxt = TIM_ENA_i ? c_HALT : c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_evn_nxt = r_evn;
        w_evc_nxt = TIM_EVC_i;
        w_irq_nxt = w_event;
        if (TIM_CLR_i) begin
            w_cnt_nxt = '0;
            w_evn_nxt = '0;
        end else if (w_wrap) begin
            if (w_event) begin
                w_cnt_nxt = (TIM_MOD_i == c_MOD_PERIODIC) ? '0 : r_cnt;
                w_evn_nxt = r_evn + 1'b1;
                w_evc_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_evn <= '0;
            r_evc <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_evn <= w_evn_nxt;
            r_evc <= w_evc_nxt;
            r_irq <= w_irq_nxt;
        end
    end

    // CLR is a strobe: the register file always gets 0 written back
    assign TIM_CLR_o = 1'b0;
    assign TIM_CNT_o = r_cnt;
    assign TIM_EVN_o = r_evn;
    assign TIM_EVC_o = r_evc;
    assign irq_o     = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_timer_ctrl : directed vectors for timer_ctrl
// Rev 1.0       : initial release
// ============================================================================
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pre, are;
    logic        clr, ena, mod;
    logic        sw_wr, sw_val;
    logic        evc_in;
    logic        clr_o, evc_o, tick_o, irq_o;
    logic [31:0] cnt_o, evn_o;

    logic        ena4;
    logic        evc4_o, clr4_o, tick4_o, irq4_o;
    logic [3:0]  cnt4_o, evn4_o;

    int n_vec = 0;
    int n_err = 0;
    int irqs, ticks;

    always #5 clk = ~clk;

    // register-file model: EVC holds its written-back value unless software writes it
    assign evc_in = sw_wr ? sw_val : evc_o;

    timer_ctrl #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .TIM_PRE_i (pre),
        .TIM_ARE_i (are),
        .TIM_CLR_i (clr),
        .TIM_ENA_i (ena),
        .TIM_MOD_i (mod),
        .TIM_EVC_i (evc_in),
        .TIM_CLR_o (clr_o),
        .TIM_CNT_o (cnt_o),
        .TIM_EVN_o (evn_o),
        .TIM_EVC_o (evc_o),
        .tick_o    (tick_o),
        .irq_o     (irq_o)
    );

    timer_ctrl #(.WIDTH(4)) dut4 (
        .clk_i     (clk),
        .rst_i     (rst),
        .TIM_PRE_i (4'd0),
        .TIM_ARE_i (4'd0),
        .TIM_CLR_i (1'b0),
        .TIM_ENA_i (ena4),
        .TIM_MOD_i (1'b0),
        .TIM_EVC_i (evc4_o),
        .TIM_CLR_o (clr4_o),
        .TIM_CNT_o (cnt4_o),
        .TIM_EVN_o (evn4_o),
        .TIM_EVC_o (evc4_o),
        .tick_o    (tick4_o),
        .irq_o     (irq4_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; pre = 0; are = 0; clr = 0; ena = 0; mod = 0;
        sw_wr = 0; sw_val = 0; ena4 = 0;
        step(2);
        chk("rst_cnt",  cnt_o,  0);
        chk("rst_evn",  evn_o,  0);
        chk("rst_evc",  evc_o,  0);
        chk("rst_irq",  irq_o,  0);
        chk("rst_tick", tick_o, 0);
        chk("rst_clro", clr_o,  0);
        rst = 1'b0;

        // periodic, PRE=0, ARE=3
        pre = 0; are = 3; mod = 0; ena = 1;
        step(1);
        chk("t1_cnt0",  cnt_o,  0);
        chk("t1_tick0", tick_o, 0);
        step(1);
        chk("t1_cnt1",  cnt_o,  1);
        chk("t1_tick1", tick_o, 1);
        step(1); chk("t1_cnt2", cnt_o, 2);
        step(1); chk("t1_cnt3", cnt_o, 3);
        chk("t1_noirq", irq_o, 0);
        step(1);
        chk("t1_wrap",  cnt_o, 0);
        chk("t1_irq",   irq_o, 1);
        chk("t1_evn",   evn_o, 1);
        chk("t1_evc",   evc_o, 1);
        step(1);
        chk("t1_cnt1b", cnt_o, 1);
        chk("t1_irqlo", irq_o, 0);

        // PRE=2, ARE=1: tick every 3, event every 6
        pre = 2; are = 1; clr = 1;
        step(1);
        clr = 0;
        chk("t2_clr_cnt",  cnt_o,  0);
        chk("t2_clr_evn",  evn_o,  0);
        chk("t2_clr_tick", tick_o, 0);
        chk("t2_clr_evc",  evc_o,  1);
        chk("t2_clr_o",    clr_o,  0);
        irqs = 0; ticks = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            irqs  += int'(irq_o);
            ticks += int'(tick_o);
        end
        chk("t2_evn",   evn_o, 10);
        chk("t2_irqs",  irqs,  10);
        chk("t2_ticks", ticks, 20);

        // one-shot, PRE=0, ARE=5
        pre = 0; are = 5; mod = 1; clr = 1;
        step(1);
        clr = 0;
        step(5);
        chk("t3_cnt5",  cnt_o, 5);
        chk("t3_pre",   irq_o, 0);
        step(1);
        chk("t3_hold",  cnt_o, 5);
        chk("t3_irq",   irq_o, 1);
        chk("t3_evn",   evn_o, 1);
        mod = 0;
        irqs = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            irqs += int'(irq_o);
        end
        chk("t3_noirq",    irqs,  0);
        chk("t3_halt_cnt", cnt_o, 5);
        chk("t3_halt_evn", evn_o, 1);
        clr = 1;
        step(1);
        clr = 0;
        chk("t3_clr_cnt", cnt_o, 0);
        chk("t3_clr_evn", evn_o, 0);
        chk("t3_clr_o",   clr_o, 0);
        step(1);
        chk("t3_rerun",   cnt_o, 1);

        // pause at cnt=7
        are = 100; clr = 1;
        step(1);
        clr = 0;
        step(7);
        chk("t4_cnt7", cnt_o, 7);
        ena = 0;
        step(1);
        chk("t4_pause1", cnt_o, 7);
        step(9);
        chk("t4_pause10", cnt_o, 7);
        ena = 1;
        step(1); chk("t4_rerun", cnt_o, 7);
        step(1); chk("t4_cnt8",  cnt_o, 8);
        step(1); chk("t4_cnt9",  cnt_o, 9);

        // software EVC clear vs event
        are = 2; clr = 1;
        step(1);
        clr = 0;
        chk("t5_evc_keep", evc_o, 1);
        sw_wr = 1; sw_val = 0;
        step(1);
        sw_wr = 0;
        chk("t5_swclr", evc_o, 0);
        step(1);
        chk("t5_stick", evc_o, 0);
        chk("t5_cnt2",  cnt_o, 2);
        sw_wr = 1; sw_val = 0;
        step(1);
        sw_wr = 0;
        chk("t5_evwin", evc_o, 1);
        chk("t5_irq",   irq_o, 1);

        // ARE lowered below the running count
        are = 100; clr = 1;
        step(1);
        clr = 0;
        step(50);
        chk("t6_cnt50", cnt_o, 50);
        are = 10;
        step(1);
        chk("t6_cnt0", cnt_o, 0);
        chk("t6_irq",  irq_o, 1);
        chk("t6_evn",  evn_o, 1);

        // reset mid-count
        step(2);
        chk("t6_cnt2", cnt_o, 2);
        rst = 1;
        step(1);
        chk("t6_rst_cnt",  cnt_o,  0);
        chk("t6_rst_evn",  evn_o,  0);
        chk("t6_rst_evc",  evc_o,  0);
        chk("t6_rst_irq",  irq_o,  0);
        chk("t6_rst_tick", tick_o, 0);
        rst = 0;

        // event counter wrap on the 4-bit instance: event every clock
        ena4 = 1;
        step(1);
        step(15);
        chk("w4_evn15", evn4_o, 4'hF);
        chk("w4_cnt",   cnt4_o, 0);
        step(1);
        chk("w4_wrap",  evn4_o, 0);
        chk("w4_irq",   irq4_o, 1);
        chk("w4_tick",  tick4_o, 1);
        chk("w4_evc",   evc4_o, 1);
        chk("w4_clro",  clr4_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
